// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg: width and lane-index helpers shared by serial framing blocks.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_pkg;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int width_for(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int lane_lsb(input int lane, input int len);
    return lane * len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_parity_framer_lane.sv
// ---------------------------------------------------------------------------
// par_lane: one serial lane, shift register plus running XOR accumulator.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module par_lane #(
  parameter int FRAME_LEN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 din,
  output logic [FRAME_LEN-1:0] word,
  output logic                 par
);

  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic                 acc_q, acc_d;

  // word and par include the bit currently on din, so the frame can be
  // captured on the same edge that samples its last bit.
  assign word = FRAME_LEN'({shift_q, din});
  assign par  = acc_q ^ din;

  always_comb begin
    shift_d = shift_q;
    acc_d   = acc_q;
    if (clr) begin
      shift_d = '0;
      acc_d   = 1'b0;
    end
    if (en) begin
      shift_d = FRAME_LEN'({shift_d, din});
      acc_d   = acc_d ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      acc_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      acc_q   <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_parity_framer.sv
// ---------------------------------------------------------------------------
// serial_parity_framer: multi-lane serial frame collector with parity
// generation/checking and a saturating parity-error counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_parity_framer
  import serial_pkg::*;
#(
  parameter int FRAME_LEN = 3,
  parameter int CHANNELS  = 1,
  parameter int CNT_W     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNELS-1:0]                  din,
  input  logic                                 din_en,
  input  logic                                 sync,
  input  logic                                 odd_sel,
  input  logic                                 chk_mode,
  output logic [CHANNELS*FRAME_LEN-1:0]        frame_out,
  output logic [CHANNELS-1:0]                  par_out,
  output logic                                 out_valid,
  output logic [width_for(FRAME_LEN+1)-1:0]    bit_cnt,
  output logic [CNT_W-1:0]                     err_cnt
);

  localparam int BIT_CNT_W = width_for(FRAME_LEN + 1);

  logic [BIT_CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [CHANNELS*FRAME_LEN-1:0] frame_q, frame_d;
  logic [CHANNELS-1:0]           par_q, par_d;
  logic                          valid_q, valid_d;
  logic [CNT_W-1:0]              err_q, err_d;

  logic                          w_done;
  logic                          w_lane_clr;
  logic                          w_lane_en;
  logic [CHANNELS*FRAME_LEN-1:0] w_word;
  logic [CHANNELS-1:0]           w_par;
  logic [CHANNELS-1:0]           w_par_sel;

  assign w_done     = din_en & ~sync & (bit_cnt_q == BIT_CNT_W'(FRAME_LEN - 1));
  // A completing bit is consumed into frame_out, so lanes restart empty.
  assign w_lane_clr = sync | w_done;
  assign w_lane_en  = din_en & ~w_done;
  assign w_par_sel  = w_par ^ {CHANNELS{odd_sel}};

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      par_lane #(
        .FRAME_LEN(FRAME_LEN)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .clr (w_lane_clr),
        .en  (w_lane_en),
        .din (din[c]),
        .word(w_word[lane_lsb(c, FRAME_LEN) +: FRAME_LEN]),
        .par (w_par[c])
      );
    end
  endgenerate

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    par_d     = par_q;
    valid_d   = w_done;
    err_d     = err_q;
    if (sync) begin
      bit_cnt_d = (din_en && FRAME_LEN > 1) ? BIT_CNT_W'(1) : '0;
    end else if (din_en) begin
      bit_cnt_d = w_done ? '0 : bit_cnt_q + BIT_CNT_W'(1);
    end
    if (w_done) begin
      frame_d = w_word;
      par_d   = w_par_sel;
      if (chk_mode && (|w_par_sel) && (err_q != {CNT_W{1'b1}})) begin
        err_d = err_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      frame_q   <= '0;
      par_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      par_q     <= par_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign bit_cnt   = bit_cnt_q;
  assign frame_out = frame_q;
  assign par_out   = par_q;
  assign out_valid = valid_q;
  assign err_cnt   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_parity_framer.sv
// ---------------------------------------------------------------------------
// tb_serial_parity_framer: directed self-checking bench, 3-bit frames, 2 lanes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_parity_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] din = 2'b00;
  logic       din_en = 1'b0;
  logic       sync = 1'b0;
  logic       odd_sel = 1'b0;
  logic       chk_mode = 1'b0;
  logic [5:0] frame_out;
  logic [1:0] par_out;
  logic       out_valid;
  logic [1:0] bit_cnt;
  logic [1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  serial_parity_framer #(
    .FRAME_LEN(3),
    .CHANNELS (2),
    .CNT_W    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_en   (din_en),
    .sync     (sync),
    .odd_sel  (odd_sel),
    .chk_mode (chk_mode),
    .frame_out(frame_out),
    .par_out  (par_out),
    .out_valid(out_valid),
    .bit_cnt  (bit_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample outputs 1 time unit after the edge.
  task automatic step(input logic [1:0] d, input logic en, input logic s);
    din    = d;
    din_en = en;
    sync   = s;
    @(posedge clk);
    #1;
    din_en = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    checks++;
    if ({frame_out, par_out, out_valid, bit_cnt, err_cnt} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: frame=%b par=%b valid=%b cnt=%0d err=%0d, required all 0",
               frame_out, par_out, out_valid, bit_cnt, err_cnt);
    end
    rst = 1'b0;
    step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0);
    checks++;
    if (bit_cnt !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_cnt: got %0d, required 2", bit_cnt);
    end
    rst = 1'b1;
    step(2'b11, 1'b1, 1'b1);
    rst = 1'b0;
    checks++;
    if (bit_cnt !== 2'd0) begin
      errors++;
      $display("FAIL midframe_reset_cnt: got %0d, required 0", bit_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midframe_reset_valid: got %b, required 0 (cycle %0d)", out_valid, i);
      end
    end
  endtask

  task automatic test_gen_even;
    odd_sel  = 1'b0;
    chk_mode = 1'b0;
    step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gen_early_valid: got %b, required 0", out_valid);
    end
    step(2'b10, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || frame_out !== 6'b111110 || par_out !== 2'b10 || bit_cnt !== 2'd0) begin
      errors++;
      $display("FAIL gen_even: valid=%b frame=%b par=%b cnt=%0d, required 1 111110 10 0",
               out_valid, frame_out, par_out, bit_cnt);
    end
    step(2'b00, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || frame_out !== 6'b111110 || par_out !== 2'b10) begin
      errors++;
      $display("FAIL gen_hold: valid=%b frame=%b par=%b, required 0 111110 10",
               out_valid, frame_out, par_out);
    end
  endtask

  task automatic test_gapped;
    logic [1:0] bits [3];
    logic [1:0] cnts [3];
    int pulses;
    bits[0] = 2'b11; bits[1] = 2'b11; bits[2] = 2'b10;
    cnts[0] = 2'd1;  cnts[1] = 2'd2;  cnts[2] = 2'd0;
    pulses = 0;
    for (int b = 0; b < 3; b++) begin
      step(bits[b], 1'b1, 1'b0);
      if (out_valid === 1'b1) pulses++;
      checks++;
      if (bit_cnt !== cnts[b]) begin
        errors++;
        $display("FAIL gapped_cnt: bit %0d got %0d, required %0d", b, bit_cnt, cnts[b]);
      end
      if (b == 2) begin
        checks++;
        if (frame_out !== 6'b111110 || par_out !== 2'b10) begin
          errors++;
          $display("FAIL gapped_frame: frame=%b par=%b, required 111110 10", frame_out, par_out);
        end
      end
      for (int g = 0; g < 2; g++) begin
        step(2'b00, 1'b0, 1'b0);
        if (out_valid === 1'b1) pulses++;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL gapped_pulses: got %0d, required 1", pulses);
    end
  endtask

  task automatic test_sync;
    step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b1);
    checks++;
    if (bit_cnt !== 2'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sync_restart: cnt=%0d valid=%b, required 1 0", bit_cnt, out_valid);
    end
    step(2'b00, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || frame_out !== 6'b000101 || par_out !== 2'b00) begin
      errors++;
      $display("FAIL sync_frame: valid=%b frame=%b par=%b, required 1 000101 00",
               out_valid, frame_out, par_out);
    end
  endtask

  task automatic test_check;
    logic [1:0] exp_err;
    odd_sel  = 1'b1;
    chk_mode = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      step(2'b11, 1'b1, 1'b0);
      step(2'b10, 1'b1, 1'b0);
      step(2'b00, 1'b1, 1'b0);
      exp_err = (f >= 3) ? 2'd3 : 2'(f);
      checks++;
      if (par_out !== 2'b10 || err_cnt !== exp_err || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL check_mode: frame %0d par=%b err=%0d valid=%b, required 10 %0d 1",
                 f, par_out, err_cnt, out_valid, exp_err);
      end
    end
    odd_sel  = 1'b0;
    chk_mode = 1'b0;
  endtask

  task automatic test_stream;
    logic [2:0] lane0, lane1;
    logic [1:0] d;
    logic       exp_valid;
    logic [1:0] exp_par;
    int         bad_valid, bad_frame;
    bad_valid = 0;
    bad_frame = 0;
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < 3; k++) begin
        d       = 2'($urandom_range(0, 3));
        odd_sel = 1'($urandom_range(0, 1));
        lane0   = {lane0[1:0], d[0]};
        lane1   = {lane1[1:0], d[1]};
        exp_par = {^lane1 ^ odd_sel, ^lane0 ^ odd_sel};
        din     = d;
        din_en  = 1'b1;
        @(posedge clk);
        #1;
        exp_valid = (k == 2);
        checks++;
        if (out_valid !== exp_valid) begin
          errors++;
          bad_valid++;
          if (bad_valid <= 5)
            $display("FAIL stream_valid: frame %0d bit %0d got %b, required %b", f, k, out_valid, exp_valid);
        end
        if (k == 2) begin
          checks++;
          if (frame_out !== {lane1, lane0} || par_out !== exp_par) begin
            errors++;
            bad_frame++;
            if (bad_frame <= 5)
              $display("FAIL stream_frame: frame %0d got %b/%b, required %b/%b",
                       f, frame_out, par_out, {lane1, lane0}, exp_par);
          end
        end
      end
    end
    din_en  = 1'b0;
    odd_sel = 1'b0;
    step(2'b00, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || err_cnt !== 2'd3) begin
      errors++;
      $display("FAIL stream_end: valid=%b err=%0d, required 0 3", out_valid, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_gen_even();
    test_gapped();
    test_sync();
    test_check();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
